// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 receive path and the scancode decoder.
//   - FSM state encoding for the frame receiver
//   - PS/2 frame constants
//   - scancode prefixes consumed by the downstream decoder
//   - odd-parity check helper
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam int         DATA_BITS = 8;
    localparam logic       START_BIT = 1'b0;
    localparam logic       STOP_BIT  = 1'b1;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT0   = 8'hE0;
    localparam logic [7:0] SC_EXT1   = 8'hE1;

    // 1 when the data byte plus parity bit do not hold an odd number of ones
    function automatic logic odd_parity_err(input logic [DATA_BITS-1:0] d, input logic p);
        return ~(^{d, p});
    endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// ps2_sync_filter: brings the raw PS/2 clock into the clk domain, removes
// glitches and produces a one-cycle pulse on each filtered falling edge.
// A second line (the PS/2 data) rides through an identical sync chain so both
// signals see the same synchronizer latency.
//   clk, rst      system clock, async active-high reset
//   i_raw         raw kbclk from the pad
//   i_aux         raw kbdat from the pad
//   o_aux_sync    synchronized kbdat
//   o_fall        one-cycle pulse, filtered kbclk went 1->0
module ps2_sync_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    input  logic i_aux,
    output logic o_aux_sync,
    output logic o_fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_aux;
    logic [CW-1:0]          r_cnt;
    logic                   r_filt;
    logic                   r_fall;
    logic                   w_sync;

    assign w_sync     = r_sync[SYNC_STAGES-1];
    assign o_aux_sync = r_aux[SYNC_STAGES-1];
    assign o_fall     = r_fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '1;
            r_aux  <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
            r_aux  <= {r_aux[SYNC_STAGES-2:0], i_aux};
        end
    end

    // Level only moves after FILTER_LEN consecutive disagreeing samples;
    // the fall pulse fires in the same cycle the filtered level drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_filt <= 1'b1;
            r_fall <= 1'b0;
        end else if (w_sync == r_filt) begin
            r_cnt  <= '0;
            r_fall <= 1'b0;
        end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
            r_cnt  <= '0;
            r_filt <= w_sync;
            r_fall <= ~w_sync;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_fall <= 1'b0;
        end
    end

endmodule

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: PS/2 frame receiver feeding the scancode decoder.
// Deserializes 11-bit frames (start, 8 data LSB first, odd parity, stop) and
// emits one byte per frame with a single-cycle strobe and error flags.
//   clk, rst     system clock, async active-high reset
//   kbclk, kbdat raw PS/2 lines from the pads (asynchronous)
//   data         last received byte, held until the next strobe
//   valid        one-cycle pulse per completed frame (good or bad)
//   err_parity   with valid: odd-parity check failed
//   err_frame    with valid: stop bit was 0
//   busy         frame in progress
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kbclk,
    input  logic       kbdat,
    output logic [7:0] data,
    output logic       valid,
    output logic       err_parity,
    output logic       err_frame,
    output logic       busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic                 w_fall;
    logic                 w_dat;
    ps2_state_t           r_state;
    logic [2:0]           r_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic [TW-1:0]        r_to;
    logic [7:0]           r_data;
    logic                 r_valid;
    logic                 r_perr;
    logic                 r_ferr;

    ps2_sync_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_clk_filt (
        .clk        (clk),
        .rst        (rst),
        .i_raw      (kbclk),
        .i_aux      (kbdat),
        .o_aux_sync (w_dat),
        .o_fall     (w_fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_to    <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            // flags are only meaningful alongside the strobe
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            if (w_fall) begin
                // a fall wins over a coincident timeout
                r_to <= '0;
                case (r_state)
                    IDLE: begin
                        if (w_dat == START_BIT) begin
                            r_state <= DATA;
                            r_cnt   <= '0;
                        end
                    end
                    DATA: begin
                        r_shift[r_cnt] <= w_dat;
                        r_cnt          <= r_cnt + 3'd1;
                        if (r_cnt == 3'd7)
                            r_state <= PARITY;
                    end
                    PARITY: begin
                        r_par   <= w_dat;
                        r_state <= STOP;
                    end
                    STOP: begin
                        r_data  <= r_shift;
                        r_valid <= 1'b1;
                        r_perr  <= odd_parity_err(r_shift, r_par);
                        r_ferr  <= (w_dat != STOP_BIT);
                        r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end else if (r_state != IDLE) begin
                if (r_to == TW'(TIMEOUT_CYCLES - 1)) begin
                    // abandon the partial frame silently
                    r_state <= IDLE;
                    r_to    <= '0;
                    r_shift <= '0;
                end else begin
                    r_to <= r_to + 1'b1;
                end
            end
        end
    end

    assign data       = r_data;
    assign valid      = r_valid;
    assign err_parity = r_perr;
    assign err_frame  = r_ferr;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_ps2_rx_frame.sv
// tb_ps2_rx_frame: directed frames on kbclk/kbdat with an expected-frame queue.
// Each complete frame pushes its expected byte/flags; one compare process pops
// on every strobe and checks held data and idle flags every cycle.
module tb_ps2_rx_frame;

    localparam int TO   = 300;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       kbclk = 1'b1;
    logic       kbdat = 1'b1;
    logic [7:0] data;
    logic       valid, err_parity, err_frame, busy;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    int         nvalid = 0;
    logic [7:0] mdl_data = 8'h00;
    logic [7:0] rx_hist[16];
    logic       last_pe = 1'b0, last_fe = 1'b0;
    logic       prev_valid = 1'b0;

    ps2_rx_frame #(
        .SYNC_STAGES    (2),
        .FILTER_LEN     (4),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .kbclk      (kbclk),
        .kbdat      (kbdat),
        .data       (data),
        .valid      (valid),
        .err_parity (err_parity),
        .err_frame  (err_frame),
        .busy       (busy)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: model state is the queue of expected frames plus the held byte.
    always @(negedge clk) begin
        if (rst) begin
            mdl_data = 8'h00;
        end else if (valid) begin
            chk("single_cycle_valid", {31'd0, prev_valid}, 32'd0);
            if (q.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("data_on_valid", {24'd0, data}, {24'd0, e.d});
                chk("err_parity", {31'd0, err_parity}, {31'd0, e.pe});
                chk("err_frame", {31'd0, err_frame}, {31'd0, e.fe});
                mdl_data = e.d;
            end
            if (nvalid < 16) rx_hist[nvalid] = data;
            last_pe = err_parity;
            last_fe = err_frame;
            nvalid++;
        end else begin
            chk("flags_idle", {30'd0, err_parity, err_frame}, 32'd0);
        end
        chk("data_held", {24'd0, data}, {24'd0, mdl_data});
        prev_valid = valid;
    end

    // Drive n bits of an LSB-first frame; data changes mid-high, optional
    // 2-cycle kbclk low glitch inserted in each high phase.
    task automatic send_bits(input logic [10:0] b, input int n, input bit glitch);
        for (int i = 0; i < n; i++) begin
            repeat (4) @(posedge clk);
            kbdat = b[i];
            if (glitch) begin
                repeat (6) @(posedge clk);
                kbclk = 1'b0;
                repeat (2) @(posedge clk);
                kbclk = 1'b1;
                repeat (8) @(posedge clk);
            end else begin
                repeat (16) @(posedge clk);
            end
            kbclk = 1'b0;
            repeat (HALF) @(posedge clk);
            kbclk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input logic stop, input bit glitch);
        logic par;
        exp_t e;
        par  = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;  // make total ones odd
        if (bad_par) par = ~par;
        e.d  = d;
        e.pe = (($countones(d) + int'(par)) % 2 == 0);
        e.fe = (stop == 1'b0);
        q.push_back(e);
        send_bits({stop, par, d, 1'b0}, 11, glitch);
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog cycle budget expired");
        $fatal(1, "watchdog");
    end

    initial begin
        #5;
        chk("reset_data", {24'd0, data}, 32'h00);
        chk("reset_ctl", {28'd0, valid, err_parity, err_frame, busy}, 32'd0);
        repeat (5) @(posedge clk);
        #3 rst = 1'b0;
        repeat (10) @(posedge clk);

        // clean 8'h1C
        send_frame(8'h1C, 0, 1'b1, 0);
        repeat (10) @(posedge clk);
        #1;
        chk("t1_data", {24'd0, data}, 32'h1C);
        chk("t1_flags", {30'd0, last_pe, last_fe}, 32'd0);
        chk("t1_busy", {31'd0, busy}, 32'd0);
        chk("t1_nvalid", nvalid, 32'd1);

        // back-to-back F0, 1C
        send_frame(8'hF0, 0, 1'b1, 0);
        send_frame(8'h1C, 0, 1'b1, 0);
        repeat (10) @(posedge clk);
        #1;
        chk("t2_nvalid", nvalid, 32'd3);
        chk("t2_first", {24'd0, rx_hist[1]}, 32'hF0);
        chk("t2_second", {24'd0, rx_hist[2]}, 32'h1C);

        // parity error
        send_frame(8'h1C, 1, 1'b1, 0);
        repeat (10) @(posedge clk);
        #1;
        chk("t3_data", {24'd0, data}, 32'h1C);
        chk("t3_flags", {30'd0, last_pe, last_fe}, 32'b10);

        // framing error
        send_frame(8'hE0, 0, 1'b0, 0);
        repeat (10) @(posedge clk);
        kbdat = 1'b1;
        #1;
        chk("t4_data", {24'd0, data}, 32'hE0);
        chk("t4_flags", {30'd0, last_pe, last_fe}, 32'b01);

        // start + 4 data bits, then line goes quiet
        send_bits({2'b11, 8'h12, 1'b0}, 5, 0);
        #1;
        chk("t5_busy_partial", {31'd0, busy}, 32'd1);
        repeat (TO - 30) @(posedge clk);
        #1;
        chk("t5_busy_before_to", {31'd0, busy}, 32'd1);
        repeat (40) @(posedge clk);
        #1;
        chk("t5_busy_after_to", {31'd0, busy}, 32'd0);
        chk("t5_no_valid", nvalid, 32'd5);
        repeat (100) @(posedge clk);
        send_frame(8'h12, 0, 1'b1, 0);
        repeat (10) @(posedge clk);
        #1;
        chk("t5_recover", {24'd0, data}, 32'h12);
        chk("t5_nvalid", nvalid, 32'd6);

        // glitched 8'h5A
        send_frame(8'h5A, 0, 1'b1, 1);
        repeat (10) @(posedge clk);
        #1;
        chk("t6_data", {24'd0, data}, 32'h5A);
        chk("t6_flags", {30'd0, last_pe, last_fe}, 32'd0);
        chk("t6_nvalid", nvalid, 32'd7);

        // reset mid-frame
        send_bits({2'b11, 8'h33, 1'b0}, 6, 0);
        #1;
        chk("t6_busy_mid", {31'd0, busy}, 32'd1);
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        chk("t6_rst_data", {24'd0, data}, 32'h00);
        chk("t6_rst_ctl", {28'd0, valid, err_parity, err_frame, busy}, 32'd0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        repeat (TO + 50) @(posedge clk);
        #1;
        chk("t6_post_rst_busy", {31'd0, busy}, 32'd0);
        chk("final_nvalid", nvalid, 32'd7);
        chk("final_queue", q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
